// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-vector layout, stall masks and interrupt-entry state encodings
// for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int STALL_WIDTH = 4;
    localparam int STALL_PC    = 0;
    localparam int STALL_IF    = 1;
    localparam int STALL_ID    = 2;
    localparam int STALL_EX    = 3;

    localparam logic [STALL_WIDTH-1:0] BUS_MASK   = 4'b0011;
    localparam logic [STALL_WIDTH-1:0] EX_MASK    = 4'b0111;
    localparam logic [STALL_WIDTH-1:0] MEM_MASK   = 4'b1111;
    localparam logic [STALL_WIDTH-1:0] DRAIN_MASK = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_FLUSH = 2'b10
    } pipe_state_e;

    function automatic logic [STALL_WIDTH-1:0] hold_stall_mask(
        input logic bus_hold,
        input logic ex_hold,
        input logic mem_hold
    );
        logic [STALL_WIDTH-1:0] mask;
        mask = {STALL_WIDTH{1'b0}};
        if (bus_hold) mask = mask | BUS_MASK;
        if (ex_hold)  mask = mask | EX_MASK;
        if (mem_hold) mask = mask | MEM_MASK;
        return mask;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stalled-cycle counter for the pipeline controller; only built
// when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_r;
    logic        at_max_s;

    assign at_max_s = (cnt_r == 32'hFFFF_FFFF);

    // clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 32'h0000_0000;
        end else if (clr) begin
            cnt_r <= 32'h0000_0000;
        end else if (inc && !at_max_s) begin
            cnt_r <= cnt_r + 32'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall vector, flush/redirect and interrupt-entry
// sequencing. Define PIPE_CTRL_PERF_EN to build the stalled-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold_bus_req_i,
    input  logic                   hold_ex_req_i,
    input  logic                   hold_mem_req_i,
    input  logic                   jump_req_i,
    input  logic [31:0]            jump_addr_i,
    input  logic                   int_req_i,
    input  logic [31:0]            int_addr_i,
    input  logic                   perf_clr_i,
    output logic [STALL_WIDTH-1:0] stall_o,
    output logic                   flush_o,
    output logic [31:0]            flush_addr_o,
    output logic                   int_ack_o,
    output logic [31:0]            stall_cnt_o
);

    pipe_state_e            state_r;
    logic [31:0]            int_addr_r;
    logic                   int_ack_r;

    logic [STALL_WIDTH-1:0] hold_stall_s;
    logic [STALL_WIDTH-1:0] stall_s;
    logic                   drain_done_s;
    logic                   flush_s;
    logic [31:0]            flush_addr_s;

    assign hold_stall_s = hold_stall_mask(hold_bus_req_i, hold_ex_req_i, hold_mem_req_i);
    assign drain_done_s = ~hold_ex_req_i & ~hold_mem_req_i;

    // interrupt-entry sequencer; the ack flop rises together with the FLUSH state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            int_addr_r <= 32'h0000_0000;
            int_ack_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    int_ack_r <= 1'b0;
                    if (int_req_i) begin
                        state_r    <= ST_DRAIN;
                        int_addr_r <= int_addr_i;
                    end else begin
                        state_r    <= ST_IDLE;
                        int_addr_r <= int_addr_r;
                    end
                end
                ST_DRAIN: begin
                    int_addr_r <= int_addr_r;
                    if (drain_done_s) begin
                        state_r   <= ST_FLUSH;
                        int_ack_r <= 1'b1;
                    end else begin
                        state_r   <= ST_DRAIN;
                        int_ack_r <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_r    <= ST_IDLE;
                    int_ack_r  <= 1'b0;
                    int_addr_r <= int_addr_r;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    int_ack_r  <= 1'b0;
                    int_addr_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    // zero-latency stall and redirect; an undefined state stalls the front end safely
    always_comb begin
        stall_s      = hold_stall_s;
        flush_s      = 1'b0;
        flush_addr_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (jump_req_i && !hold_stall_s[STALL_EX]) begin
                    flush_s      = 1'b1;
                    flush_addr_s = jump_addr_i;
                end else begin
                    flush_s      = 1'b0;
                    flush_addr_s = 32'h0000_0000;
                end
            end
            ST_DRAIN: begin
                stall_s = hold_stall_s | DRAIN_MASK;
            end
            ST_FLUSH: begin
                stall_s      = {STALL_WIDTH{1'b0}};
                flush_s      = 1'b1;
                flush_addr_s = int_addr_r;
            end
            default: begin
                stall_s      = hold_stall_s | DRAIN_MASK;
                flush_s      = 1'b0;
                flush_addr_s = 32'h0000_0000;
            end
        endcase
    end

    assign stall_o      = stall_s;
    assign flush_o      = flush_s;
    assign flush_addr_o = flush_addr_s;
    assign int_ack_o    = int_ack_r;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr_i),
        .inc   (stall_s[STALL_PC] & ~flush_s),
        .cnt   (stall_cnt_o)
    );
`else
    logic unused_perf_clr_s;
    assign unused_perf_clr_s = perf_clr_i;
    assign stall_cnt_o       = 32'h0000_0000;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the core. Collects hold requests from fetch, execute and memory stages, plus redirect requests from branch/jump resolution and interrupt entry. Produces the per-stage stall vector, the global flush, and the redirect address consumed by the PC generator and every inter-stage register (IF/ID, ID/EX, …). Interrupt entry is sequenced by a small FSM so no in-flight memory or multi-cycle EX operation is torn.

## Interface
Parameters:
- none; stall width and stage indices come from shared defines.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hold_bus_req_i  in  1  fetch bus not ready / not granted
- hold_ex_req_i  in  1  multi-cycle EX op (divider) busy
- hold_mem_req_i  in  1  load/store waiting on data bus
- jump_req_i  in  1  branch/jump taken, resolved in EX
- jump_addr_i  in  32  jump target
- int_req_i  in  1  interrupt/exception entry request, level, held until int_ack_o
- int_addr_i  in  32  trap vector address
- perf_clr_i  in  1  clear stall counter
- stall_o  out  `STALL_WIDTH  per-stage stall, bit index `STALL_PC/`STALL_IF/`STALL_ID/`STALL_EX
- flush_o  out  1  flush front-end registers, redirect PC
- flush_addr_o  out  32  redirect address, valid when flush_o=1, else 0
- int_ack_o  out  1  one-cycle pulse: interrupt redirect issued
- stall_cnt_o  out  32  stalled-cycle counter

## Operation
- Stall masks, ORed: hold_bus → {PC,IF}; hold_ex → {PC,IF,ID}; hold_mem → {PC,IF,ID,EX}.
- Jump: accepted only when the computed stall_o[`STALL_EX]=0 and FSM=IDLE. Then flush_o=1 and flush_addr_o=jump_addr_i in the same cycle (combinational). Stall bits stay as computed; flush overrides them at the receiving registers.
- Jump while EX is stalled is not acted on; EX re-presents it.
- FSM states: IDLE, DRAIN, FLUSH.
  - IDLE: int_req_i=1 → latch int_addr_i into int_addr_q, go DRAIN.
  - DRAIN: force stall_o {PC,IF,ID}=1. When hold_mem_req_i=0 and hold_ex_req_i=0 → FLUSH.
  - FLUSH: flush_o=1, flush_addr_o=int_addr_q, int_ack_o=1, stall_o=0 → IDLE.
- int_req_i outside IDLE is ignored. In FLUSH, the requester drops it on int_ack_o.
- jump_req_i in DRAIN/FLUSH is ignored; the interrupt wins and the trap unit owns the return PC.
- Same cycle in IDLE, jump_req_i and int_req_i: jump flush issues that cycle, and the FSM enters DRAIN next cycle.

## Timing
- Reset (async): FSM=IDLE, int_addr_q=0, stall_cnt_o=0. With inputs low, stall_o=0, flush_o=0, flush_addr_o=0, int_ack_o=0.
- Stall and jump paths: zero latency, combinational.
- Interrupt: int_req_i high at cycle n → DRAIN at n+1 → FLUSH/int_ack_o at n+2 at earliest. Each cycle of EX/mem hold in DRAIN adds one cycle.
- Reset asserted in DRAIN/FLUSH aborts entry; no int_ack_o is produced.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt_o increments each cycle with stall_o[`STALL_PC]=1 and flush_o=0.
  - Saturates at 32'hFFFF_FFFF.
  - perf_clr_i=1 sets it to 0 next cycle, with priority over increment.
- PIPE_CTRL_PERF_EN undefined: stall_cnt_o tied to 0, perf_clr_i ignored, no counter flops.

## Structure
- defines.sv holds `STALL_WIDTH (4) and `STALL_PC=0, `STALL_IF=1, `STALL_ID=2, `STALL_EX=3, plus the FSM state encodings (2 bits).
- State, int_addr_q and counter flops use the existing gen_en_dff/gen_dff cells.
- One sub-module, pipe_ctrl_perf: the saturating counter, instantiated only under PIPE_CTRL_PERF_EN.

## Test plan
- hold_mem_req_i=1 for 3 cycles → stall_o=4'b1111 for exactly 3 cycles; stall_cnt_o=3 (PERF_EN).
- jump_req_i=1, jump_addr_i=32'h0000_0100, no holds → same cycle flush_o=1, flush_addr_o=32'h100; next cycle flush_o=0.
- jump_req_i=1 with hold_mem_req_i=1 → flush_o=0; hold drops → flush_o=1 that cycle.
- int_req_i=1, int_addr_i=32'h0000_0080, hold_ex_req_i=1 for 2 cycles → DRAIN 2+ cycles with stall_o[2:0]=3'b111, then one cycle of flush_o=1, flush_addr_o=32'h80, int_ack_o=1.
- jump_req_i and int_req_i together in IDLE → jump flush that cycle, interrupt flush 2 cycles later; a jump in DRAIN is ignored.
- rst_n low during DRAIN → all outputs 0 immediately, no int_ack_o; stall_cnt_o at 32'hFFFF_FFFF stays saturated under stall; perf_clr_i clears it to 0.
